// File: rtl/fir_mac_filt.sv
// rtl/fir_mac_filt.sv - time-multiplexed multi-channel FIR MAC filter with shared coefficient ROM
// Define FIRFILT_SAT_EN to clamp outputs to the DATA_W signed range instead of wrapping.
module fir_mac_filt #(
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 16,
  parameter int ACC_W   = 32,
  parameter int TAPS    = 1021,
  parameter int ADDR_W  = 10,
  parameter int NUM_CH  = 2,
  parameter int FRAC_SH = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sequencing,
  input  logic [NUM_CH*DATA_W-1:0] smpl_in,
  output logic [ADDR_W-1:0]        coef_addr,
  input  logic [COEF_W-1:0]        coef_in,
  output logic [NUM_CH*DATA_W-1:0] smpl_out,
  output logic                     valid,
  output logic                     busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_WAIT} state_t;

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);
`ifdef FIRFILT_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
`endif

  state_t                     state_q, state_d;
  logic                       seq_prev_q, seq_prev_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [NUM_CH*DATA_W-1:0]   smpl_r_q, smpl_r_d;
  logic signed [ACC_W-1:0]    acc_q [NUM_CH];
  logic signed [ACC_W-1:0]    acc_d [NUM_CH];
  logic [NUM_CH*DATA_W-1:0]   smpl_out_q, smpl_out_d;
  logic                       valid_q, valid_d;

  logic signed [DATA_W+COEF_W-1:0] prod [NUM_CH];
  logic signed [ACC_W-1:0]         sum  [NUM_CH];
  logic [NUM_CH*DATA_W-1:0]        result;
  logic                            add_en;

  // smpl_r_q lags smpl_in by one cycle so it lines up with the registered ROM data.
  always_comb begin
    result = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      prod[ch] = $signed(smpl_r_q[ch*DATA_W +: DATA_W]) * $signed(coef_in);
      sum[ch]  = acc_q[ch] + ACC_W'(prod[ch]);
`ifdef FIRFILT_SAT_EN
      if ((sum[ch] >>> FRAC_SH) > SAT_MAX) begin
        result[ch*DATA_W +: DATA_W] = SAT_MAX[DATA_W-1:0];
      end else if ((sum[ch] >>> FRAC_SH) < SAT_MIN) begin
        result[ch*DATA_W +: DATA_W] = SAT_MIN[DATA_W-1:0];
      end else begin
        result[ch*DATA_W +: DATA_W] = DATA_W'(sum[ch] >>> FRAC_SH);
      end
`else
      result[ch*DATA_W +: DATA_W] = DATA_W'(sum[ch] >>> FRAC_SH);
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    seq_prev_d = sequencing;
    addr_d     = addr_q;
    smpl_r_d   = smpl_in;
    acc_d      = acc_q;
    smpl_out_d = smpl_out_q;
    valid_d    = 1'b0;
    // No product is ready during the first ACCUM cycle (ROM still fetching tap 0).
    add_en     = ((state_q == S_ACCUM) && (addr_q != '0)) || (state_q == S_FLUSH);

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (sequencing && !seq_prev_q) begin
          state_d = S_ACCUM;
          for (int ch = 0; ch < NUM_CH; ch++) acc_d[ch] = '0;
        end
      end
      S_ACCUM: begin
        if (!sequencing) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else begin
          if (add_en) acc_d = sum;
          if (addr_q == LAST_TAP) begin
            state_d = S_FLUSH;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      S_FLUSH: begin
        acc_d      = sum;
        smpl_out_d = result;
        valid_d    = 1'b1;
        state_d    = sequencing ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (!sequencing) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      seq_prev_q <= 1'b0;
      addr_q     <= '0;
      smpl_r_q   <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) acc_q[ch] <= '0;
      smpl_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_prev_q <= seq_prev_d;
      addr_q     <= addr_d;
      smpl_r_q   <= smpl_r_d;
      acc_q      <= acc_d;
      smpl_out_q <= smpl_out_d;
      valid_q    <= valid_d;
    end
  end

  assign coef_addr = addr_q;
  assign smpl_out  = smpl_out_q;
  assign valid     = valid_q;
  assign busy      = (state_q == S_ACCUM) || (state_q == S_FLUSH);

endmodule

// File: tb/tb_fir_mac_filt.sv
// tb/tb_fir_mac_filt.sv - scoreboard bench for fir_mac_filt with TAPS=4, NUM_CH=2, ACC_W=40
module tb_fir_mac_filt;
  localparam int DW = 16, CW = 16, AW = 40, TAPS = 4, ADW = 4, NCH = 2, FS = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            sequencing;
  logic [NCH*DW-1:0] smpl_in;
  logic [ADW-1:0]  coef_addr;
  logic [CW-1:0]   coef_in;
  logic [NCH*DW-1:0] smpl_out;
  logic            valid;
  logic            busy;

  fir_mac_filt #(
    .DATA_W(DW), .COEF_W(CW), .ACC_W(AW), .TAPS(TAPS),
    .ADDR_W(ADW), .NUM_CH(NCH), .FRAC_SH(FS)
  ) dut (
    .clk(clk), .rst(rst), .sequencing(sequencing), .smpl_in(smpl_in),
    .coef_addr(coef_addr), .coef_in(coef_in), .smpl_out(smpl_out),
    .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [CW-1:0] rom [16];
  always @(posedge clk) coef_in <= rom[coef_addr];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NCH*DW-1:0] data;
    int                at;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual smpl_out %0h at cycle %0d required no valid", smpl_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("smpl_out", smpl_out, mon_e.data);
        chk("valid_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic run(input logic [DW-1:0] s0, input logic [DW-1:0] s1, input int high,
                     input bit expect_v, input logic [NCH*DW-1:0] exp_data, input bit chk_addr);
    int c0;
    @(posedge clk); #1;
    sequencing = 1'b1;
    smpl_in    = {s1, s0};
    c0         = cyc;
    if (expect_v) exp_q.push_back('{exp_data, c0 + TAPS + 2});
    for (int i = 1; i < high; i++) begin
      @(posedge clk); #1;
      if (chk_addr && i <= TAPS) begin
        chk("coef_addr", coef_addr, i - 1);
        chk("busy_run", busy, 1);
      end
    end
    @(posedge clk); #1;
    sequencing = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [NCH*DW-1:0] EXP_BASIC = {16'h0000, 16'h0400};
`ifdef FIRFILT_SAT_EN
  localparam logic [NCH*DW-1:0] EXP_SAT = {16'h8000, 16'h7FFF};
`else
  localparam logic [NCH*DW-1:0] EXP_SAT = {16'h0007, 16'hFFF8};
`endif

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = '0;
    rom[0] = 16'h4000; rom[1] = 16'h2000; rom[2] = 16'h0000; rom[3] = 16'hC000;
    rst = 1'b1; sequencing = 1'b0; smpl_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_smpl_out", smpl_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_coef_addr", coef_addr, 0);
    rst = 1'b0;
    idle(2);

    run(16'h1000, 16'h0000, 7, 1'b1, EXP_BASIC, 1'b1);
    idle(3);

    run(16'h3000, 16'h1000, 3, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_hold", smpl_out, EXP_BASIC);
    idle(4);

    @(posedge clk); #1;
    sequencing = 1'b1; smpl_in = {16'h0000, 16'h1000};
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; sequencing = 1'b0;
    chk("midrst_smpl_out", smpl_out, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_coef_addr", coef_addr, 0);
    idle(2);
    run(16'h1000, 16'h0000, 7, 1'b1, EXP_BASIC, 1'b0);
    idle(3);

    run(16'h1000, 16'h0000, 7, 1'b1, EXP_BASIC, 1'b0);
    run(16'h2000, 16'h0000, 7, 1'b1, {16'h0000, 16'h0800}, 1'b0);
    idle(3);

    run(16'h1000, 16'h0000, 10, 1'b1, EXP_BASIC, 1'b0);
    idle(3);

    for (int i = 0; i < TAPS; i++) rom[i] = 16'h7FFF;
    run(16'h7FFF, 16'h8001, 7, 1'b1, EXP_SAT, 1'b0);
    idle(8);

    chk("pending_expects", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
